// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: 1149.1 TAP state encoding, command opcodes,
// control FSM states and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR       = 4'd0,
    TAP_RTI       = 4'd1,
    TAP_SEL_DR    = 4'd2,
    TAP_CAP_DR    = 4'd3,
    TAP_SHIFT_DR  = 4'd4,
    TAP_EXIT1_DR  = 4'd5,
    TAP_PAUSE_DR  = 4'd6,
    TAP_EXIT2_DR  = 4'd7,
    TAP_UPDATE_DR = 4'd8,
    TAP_SEL_IR    = 4'd9,
    TAP_CAP_IR    = 4'd10,
    TAP_SHIFT_IR  = 4'd11,
    TAP_EXIT1_IR  = 4'd12,
    TAP_PAUSE_IR  = 4'd13,
    TAP_EXIT2_IR  = 4'd14,
    TAP_UPDATE_IR = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_PRE   = 3'd1,
    C_NAV   = 3'd2,
    C_SHIFT = 3'd3,
    C_POST  = 3'd4,
    C_DONE  = 3'd5
  } ctrl_state_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:       n = tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:       n = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_DR:    n = tms ? TAP_SEL_IR    : TAP_CAP_DR;
      TAP_CAP_DR:    n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:  n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:  n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:  n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:  n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: n = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_IR:    n = tms ? TAP_TLR       : TAP_CAP_IR;
      TAP_CAP_IR:    n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:  n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:  n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:  n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:  n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: n = tms ? TAP_SEL_DR    : TAP_RTI;
      default:       n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clks low then CLK_DIV clks high while enabled,
// with strobes flagging the clk edge on which TCK rises or falls.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       last;

  assign last     = (cnt_q == DIV_M1);
  assign rise_stb = en && last && !tck_q;
  assign fall_stb = en && last && tck_q;
  assign tck      = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: runs RESET / IDLE / IR_SCAN / DR_SCAN commands on a TAP and
// mirrors its state. Define JTAG_MASTER_STATE_OBS_EN to expose tap_state.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               TRST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
`ifdef JTAG_MASTER_STATE_OBS_EN
  ,
  output logic [3:0]         tap_state
`endif
);

  ctrl_state_e        ctrl_q, ctrl_d;
  cmd_op_e            op_q, op_d;
  logic [4:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [4:0]         idx_q, idx_d;
  tap_state_e         mirror_q, mirror_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic       tck_en, rise_stb, fall_stb, load;
  logic [4:0] nav_last;
  logic       is_scan;

  assign tck_en = (ctrl_q == C_PRE) || (ctrl_q == C_NAV) ||
                  (ctrl_q == C_SHIFT) || (ctrl_q == C_POST);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst_n    (TRST_N),
    .en       (tck_en),
    .tck      (TCK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign is_scan = (op_q == OP_IR_SCAN) || (op_q == OP_DR_SCAN);

  always_comb begin
    case (op_q)
      OP_RESET:   nav_last = 5'd5;
      OP_IDLE:    nav_last = len_q;
      OP_IR_SCAN: nav_last = 5'd3;
      default:    nav_last = 5'd2;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    idx_d      = idx_q;
    mirror_d   = mirror_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    load       = 1'b0;

    // TDO is captured on the same clk edge at which TCK rises
    if (rise_stb) begin
      mirror_d = tap_next(mirror_q, tms_q);
      if (ctrl_q == C_SHIFT) rsp_data_d[idx_q] = TDO;
    end

    case (ctrl_q)
      C_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op_e'(cmd_op);
          len_d      = cmd_len;
          data_d     = cmd_data;
          idx_d      = '0;
          rsp_data_d = '0;
          load       = 1'b1;
          ctrl_d     = (op_d != OP_RESET && mirror_q == TAP_TLR) ? C_PRE : C_NAV;
        end
      end
      C_PRE: begin
        if (fall_stb) begin
          load   = 1'b1;
          idx_d  = '0;
          ctrl_d = C_NAV;
        end
      end
      C_NAV: begin
        if (fall_stb) begin
          load = 1'b1;
          if (idx_q == nav_last) begin
            idx_d  = '0;
            ctrl_d = is_scan ? C_SHIFT : C_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      C_SHIFT: begin
        if (fall_stb) begin
          load = 1'b1;
          if (idx_q == len_q) begin
            idx_d  = '0;
            ctrl_d = C_POST;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      C_POST: begin
        if (fall_stb) begin
          load = 1'b1;
          if (idx_q == 5'd1) begin
            idx_d  = '0;
            ctrl_d = C_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      C_DONE:  ctrl_d = C_IDLE;
      default: ctrl_d = C_IDLE;
    endcase

    // TMS/TDI for the next TCK cycle are loaded at acceptance or on a TCK fall
    if (load) begin
      tdi_d = 1'b0;
      case (ctrl_d)
        C_PRE: tms_d = 1'b0;
        C_NAV: begin
          case (op_d)
            OP_RESET:   tms_d = (idx_d < 5'd5);
            OP_IDLE:    tms_d = 1'b0;
            OP_IR_SCAN: tms_d = (idx_d < 5'd2);
            default:    tms_d = (idx_d == 5'd0);
          endcase
        end
        C_SHIFT: begin
          tms_d = (idx_d == len_d);
          tdi_d = data_d[idx_d];
        end
        C_POST:  tms_d = (idx_d == 5'd0);
        default: tms_d = tms_q;
      endcase
    end

    rsp_valid_d = (ctrl_d == C_DONE) && (ctrl_q != C_DONE);
    cmd_ready_d = (ctrl_d == C_IDLE);
  end

  always_ff @(posedge clk or negedge TRST_N) begin
    if (!TRST_N) begin
      ctrl_q      <= C_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      mirror_q    <= TAP_TLR;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      mirror_q    <= mirror_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

`ifdef JTAG_MASTER_STATE_OBS_EN
  assign tap_state = mirror_q;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master: scoreboarded responses, TMS sequence
// model, TCK phase lengths and reset/abort behaviour.
module tb_jtag_master;

  localparam int DIV = 3;
  localparam int ML  = 32;

  logic          clk = 1'b0;
  logic          TRST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [4:0]    cmd_len = 5'd0;
  logic [ML-1:0] cmd_data = '0;
  logic          cmd_ready, rsp_valid;
  logic [ML-1:0] rsp_data;
  logic          TCK, TMS, TDI, TDO;
  logic [1:0]    tdo_mode = 2'd0;
`ifdef JTAG_MASTER_STATE_OBS_EN
  logic [3:0]    tap_state;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  logic [ML-1:0] exp_q[$];
  bit   tms_log[$];
  int   hi_runs[$];
  int   lo_runs[$];
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  int   viol = 0;
  logic tck_prev = 1'b0;
  logic tms_prev = 1'b1;
  logic tdi_prev = 1'b0;
  bit   in_tlr = 1'b1;

  always #5 clk = ~clk;

  // 0: loopback TDI, 1: constant 0, 2: constant 1
  assign TDO = (tdo_mode == 2'd0) ? TDI : (tdo_mode == 2'd1) ? 1'b0 : 1'b1;

  jtag_master #(.CLK_DIV(DIV), .MAX_LEN(ML)) dut (
    .clk       (clk),
    .TRST_N    (TRST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
`ifdef JTAG_MASTER_STATE_OBS_EN
    ,
    .tap_state (tap_state)
`endif
  );

  // TCK monitor: TMS per rising edge, phase lengths, TMS/TDI movement while TCK high
  always @(negedge clk) begin
    if (TCK === 1'b1 && tck_prev === 1'b0) begin
      tms_log.push_back(TMS);
      lo_runs.push_back(lo_cnt);
    end
    if (TCK === 1'b0 && tck_prev === 1'b1) hi_runs.push_back(hi_cnt);
    if (TCK === 1'b1 && tck_prev === 1'b1 && (TMS !== tms_prev || TDI !== tdi_prev))
      viol <= viol + 1;
    hi_cnt   <= (TCK === 1'b1) ? hi_cnt + 1 : 0;
    lo_cnt   <= (TCK === 1'b0 && cmd_ready === 1'b0 && TRST_N === 1'b1) ? lo_cnt + 1 : 0;
    tck_prev <= TCK;
    tms_prev <= TMS;
    tdi_prev <= TDI;
  end

  function automatic void exp_tms(input int op, input int len, input bit tlr,
                                  output bit [63:0] seq, output int n);
    seq = '0;
    n   = 0;
    if (op != 0 && tlr) n++;
    case (op)
      0: begin
        for (int i = 0; i < 5; i++) begin seq[n] = 1'b1; n++; end
        n++;
      end
      1: n += len + 1;
      2: begin seq[n] = 1'b1; seq[n+1] = 1'b1; n += 4; end
      default: begin seq[n] = 1'b1; n += 3; end
    endcase
    if (op >= 2) begin
      n += len;
      seq[n] = 1'b1;
      n++;
      seq[n] = 1'b1;
      n += 2;
    end
  endfunction

  function automatic logic [ML-1:0] len_mask(input int len);
    logic [ML-1:0] m;
    m = '1;
    if (len < 31) m = (32'd1 << (len + 1)) - 32'd1;
    return m;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [4:0] len,
                       input logic [ML-1:0] data, input logic [ML-1:0] exp, output int base);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    if (cmd_ready !== 1'b1) begin
      n_vec++; n_fail++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    base      = tms_log.size();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = ~len;
    cmd_data  = ~data;
  endtask

  task automatic wait_rsp(input string name, input int base, input bit [63:0] eseq, input int en);
    int t = 0;
    int ngot;
    logic [ML-1:0] exp;
    bit [63:0] got;
    while (rsp_valid !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
      exp_q.delete();
      return;
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (rsp_data !== exp) begin
      n_fail++;
      $display("FAIL %s_rsp: rsp_data=%h required %h", name, rsp_data, exp);
    end
    ngot = tms_log.size() - base;
    got  = '0;
    for (int i = 0; i < ngot && i < 64; i++) got[i] = tms_log[base + i];
    n_vec++;
    if (ngot != en) begin
      n_fail++;
      $display("FAIL %s_tcks: tck count=%0d required %0d", name, ngot, en);
    end
    n_vec++;
    if (got !== eseq) begin
      n_fail++;
      $display("FAIL %s_tms: tms seq=%h required %h", name, got, eseq);
    end
`ifdef JTAG_MASTER_STATE_OBS_EN
    n_vec++;
    if (tap_state !== 4'd1) begin
      n_fail++;
      $display("FAIL %s_tap: tap_state=%0d required 1", name, tap_state);
    end
`endif
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_data !== exp) begin
      n_fail++;
      $display("FAIL %s_pulse: rsp_valid=%b rsp_data=%h required 0 %h", name, rsp_valid, rsp_data, exp);
    end
    $display("cmd %s: tcks=%0d tms=%h rsp=%h", name, ngot, got, exp);
  endtask

  task automatic run_cmd(input string name, input int op, input int len,
                         input logic [ML-1:0] data, input logic [ML-1:0] exp);
    bit [63:0] seq;
    int n;
    int base;
    exp_tms(op, len, in_tlr, seq, n);
    issue(2'(op), 5'(len), data, exp, base);
    wait_rsp(name, base, seq, n);
    in_tlr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    TRST_N = 1'b0;
    repeat (2) @(negedge clk);
    TRST_N = 1'b1;
    in_tlr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({TCK, TMS, TDI, cmd_ready, rsp_valid} !== 5'b01000 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: TCK,TMS,TDI,rdy,vld=%b rsp=%h required 01000 0",
               {TCK, TMS, TDI, cmd_ready, rsp_valid}, rsp_data);
    end
`ifdef JTAG_MASTER_STATE_OBS_EN
    n_vec++;
    if (tap_state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_tap: tap_state=%0d required 0", tap_state);
    end
`endif
    TRST_N = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
    $display("reset: outputs checked, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_reset_cmd();
    run_cmd("reset_cmd", 0, 0, 32'hDEAD_BEEF, '0);
  endtask

  task automatic test_dr_loop();
    tdo_mode = 2'd0;
    run_cmd("dr_a5", 3, 7, 32'h0000_00A5, 32'h0000_00A5);
  endtask

  task automatic test_ir_from_tlr();
    pulse_reset();
    tdo_mode = 2'd0;
    run_cmd("ir_tlr", 2, 3, 32'h0000_000E, 32'h0000_000E);
  endtask

  task automatic test_dr_zero_phases();
    int hb, lb, bad;
    tdo_mode = 2'd1;
    hb = hi_runs.size();
    lb = lo_runs.size();
    run_cmd("dr_ff", 3, 31, 32'hFFFF_FFFF, '0);
    bad = 0;
    for (int i = hb; i < hi_runs.size(); i++) if (hi_runs[i] != DIV) bad++;
    for (int i = lb; i < lo_runs.size(); i++) if (lo_runs[i] != DIV) bad++;
    n_vec++;
    if (bad != 0 || hi_runs.size() - hb != 37 || lo_runs.size() - lb != 37) begin
      n_fail++;
      $display("FAIL tck_phase: bad=%0d hi=%0d lo=%0d required 0 37 37",
               bad, hi_runs.size() - hb, lo_runs.size() - lb);
    end
    $display("phases: %0d high / %0d low runs checked against %0d clks",
             hi_runs.size() - hb, lo_runs.size() - lb, DIV);
  endtask

  task automatic test_tdo_ones();
    tdo_mode = 2'd2;
    run_cmd("dr_ones", 3, 9, 32'h1234_5678, 32'h0000_03FF);
    run_cmd("ir_len0", 2, 0, 32'h0, 32'h0000_0001);
    tdo_mode = 2'd0;
  endtask

  task automatic test_idle();
    run_cmd("idle4", 1, 4, 32'hFFFF_FFFF, '0);
    pulse_reset();
    run_cmd("idle_tlr", 1, 0, 32'h0, '0);
  endtask

  task automatic test_abort();
    int base, t;
    bit seen;
    logic [ML-1:0] d;
    tdo_mode = 2'd0;
    d = $urandom;
    issue(2'd3, 5'd31, d, d, base);
    t = 0;
    while (tms_log.size() < base + 8 && t < 2000) begin @(negedge clk); t++; end
    n_vec++;
    if (tms_log.size() < base + 8) begin
      n_fail++;
      $display("FAIL abort_progress: tcks=%0d required >=8", tms_log.size() - base);
    end
    TRST_N = 1'b0;
    @(negedge clk);
    n_vec++;
    if (TCK !== 1'b0 || TMS !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: TCK=%b TMS=%b rsp_valid=%b required 0 1 0", TCK, TMS, rsp_valid);
    end
    TRST_N = 1'b1;
    exp_q.delete();
    in_tlr = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: cmd_ready=%b required 1", cmd_ready);
    end
    repeat (100) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_norsp: rsp_valid seen=%b required 0", seen);
    end
    $display("abort: reset during shift, rsp seen=%b", seen);
    d = $urandom;
    run_cmd("after_abort", 3, 7, d, d & 32'hFF);
  endtask

  task automatic test_back_to_back();
    int op, len;
    logic [ML-1:0] d;
    tdo_mode = 2'd0;
    for (int k = 0; k < 8; k++) begin
      op  = $urandom_range(1, 3);
      len = $urandom_range(0, 31);
      d   = $urandom;
      run_cmd($sformatf("b2b%0d_op%0d_len%0d", k, op, len), op, len, d,
              (op == 1) ? '0 : (d & len_mask(len)));
    end
  endtask

  task automatic test_tck_stability();
    n_vec++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL tck_high_stable: TMS/TDI changes while TCK high=%0d required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_reset_cmd();
    test_dr_loop();
    test_ir_from_tlr();
    test_dr_zero_phases();
    test_tdo_ones();
    test_idle();
    test_abort();
    test_back_to_back();
    test_tck_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, default 2, gives clk cycles per TCK half-period (legal range 1..255).
REQ-002 Parameter MAX_LEN, default 32, is the maximum scan length in bits.
REQ-003 clk  input  1  system clock; the only clock; all state changes on posedge clk.
REQ-004 TRST_N  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge clk.
REQ-007 cmd_op  input  2  operation: 0=RESET, 1=IDLE, 2=IR_SCAN, 3=DR_SCAN.
REQ-008 cmd_len  input  5  bit count minus 1 (0..31 means 1..32 bits or TCK cycles).
REQ-009 cmd_data  input  MAX_LEN  TDI data, LSB shifted first.
REQ-010 rsp_valid  output  1  one-clk pulse: command complete.
REQ-011 rsp_data  output  MAX_LEN  captured TDO; bit i is TDO on shift bit i; unused upper bits are 0.
REQ-012 TCK  output  1  generated test clock.
REQ-013 TMS  output  1  test mode select.
REQ-014 TDI  output  1  test data in.
REQ-015 TDO  input  1  test data out from the target TAP.

Function
REQ-016 The TCK cycle shall be: low for CLK_DIV clks, then high for CLK_DIV clks; TMS/TDI change only on the clk where TCK falls, or in the first low phase; TDO is sampled on the clk where TCK rises.
REQ-017 TCK shall be held low and TMS/TDI shall be held stable when no command is executing.
REQ-018 The block shall track the target TAP state in a 16-state mirror FSM with standard 1149.1 transitions, updated on every TCK rising edge from TMS.
REQ-019 The control FSM shall use states IDLE, PRE (move to Run-Test/Idle), NAV (walk TMS path), SHIFT, POST, DONE.
REQ-020 cmd_ready shall be 1 only in IDLE; a command is latched on acceptance and later cmd_* changes shall be ignored.
REQ-021 RESET: 5 TCKs with TMS=1, then 1 TCK with TMS=0; the mirror shall end in Run-Test/Idle.
REQ-022 IDLE: cmd_len+1 TCKs with TMS=0, in Run-Test/Idle.
REQ-023 IR_SCAN from Run-Test/Idle: TMS 1,1,0,0; then cmd_len+1 shift TCKs with TMS=0, except TMS=1 on the last bit; then TMS 1,0, ending in Run-Test/Idle.
REQ-024 DR_SCAN: same as IR_SCAN but with navigation TMS 1,0,0.
REQ-025 A scan or IDLE command issued when the mirror is in Test-Logic-Reset shall first emit one TCK with TMS=0 (PRE).
REQ-026 TDI shall carry cmd_data[i] during shift bit i; it is don't-care (driven 0) outside SHIFT.
REQ-027 rsp_valid shall pulse in the clk after the final TCK falling edge; rsp_data shall then be stable until the next acceptance. rsp_data shall be 0 for RESET and IDLE.
REQ-028 Total TCKs: DR_SCAN = len+6; IR_SCAN = len+7; add 1 for PRE.

Reset
REQ-029 While TRST_N=0: TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, mirror=Test-Logic-Reset, FSM=IDLE.
REQ-030 Reset mid-command shall abort the command with no rsp_valid; cmd_ready=1 on the first clk after TRST_N deasserts.

Configuration
REQ-031 With macro JTAG_MASTER_STATE_OBS_EN defined, the block shall add output tap_state[3:0] carrying the mirror state with the shared encoding (Test-Logic-Reset=0 ... Update-IR=15).
REQ-032 Without JTAG_MASTER_STATE_OBS_EN, no tap_state port shall exist and function shall be otherwise identical.

Structure
REQ-033 Package jtag_pkg shall hold the 4-bit TAP state encoding (16 constants), the cmd_op encoding and the next-state function.
REQ-034 The sub-module jtag_tck_gen (TCK divider that emits rise and fall strobes) shall be instantiated once.

Verification
REQ-035 After reset, RESET cmd -> 6 TCKs, TMS=1,1,1,1,1,0, then rsp_valid pulse; tap_state=1.
REQ-036 DR_SCAN len=7, data=0xA5, TDO loopback from TDI -> 13 TCKs; rsp_data=0x000000A5; end tap_state=1.
REQ-037 IR_SCAN len=3, data=0xE, from Test-Logic-Reset -> PRE then 11 TCKs, TMS sequence 0,1,1,0,0,0,0,0,1,1,0.
REQ-038 DR_SCAN len=31, data=0xFFFFFFFF, TDO=0 -> rsp_data=0; measure CLK_DIV=3 TCK high/low = 3 clks each.
REQ-039 TRST_N pulsed low during the SHIFT of a DR_SCAN -> no rsp_valid; TMS=1, TCK=0; next command executes normally.
